heartbeat_anim: RTL
===================

# heartbeat_anim

Parametrised frame-animation generator for the four-digit seven-segment display. A programmable divider paces a frame counter. The counter steps through a ROM of 4-digit segment patterns in forward, reverse or ping-pong order, and the pattern ROM defaults to the three-frame heartbeat. It also supports run/pause, single-step and speed select. Its led0..led3 outputs feed disp_mux in0..in3 directly.

## Interface
- CLK_DIV, default 1388889: clock cycles per frame at speed 0 (72 Hz at 100 MHz).
- DIV_W, default 22: divider counter width; must satisfy 2^DIV_W > CLK_DIV.
- FRAMES, default 3: number of active frames, 1..2^FRAME_W.
- FRAME_W, default 3: frame index width.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  1 = run, 0 = pause.
- mode  in  2  00 forward-wrap, 01 reverse-wrap, 10 ping-pong, 11 hold.
- speed  in  2  frame period = CLK_DIV >> speed cycles, minimum 1.
- step  in  1  single-cycle pulse; advances one frame while en=0.
- tick  out  1  one-cycle frame-advance strobe.
- wrap  out  1  one-cycle strobe, coincident with tick, on an end-of-sequence advance.
- frame  out  FRAME_W  current frame index.
- led0..led3  out  8 each  active-low segment patterns, dp in bit 7.

## Operation
- period = max(1, CLK_DIV >> speed).
- Divider:
  - en=1: counts 0..period-1; terminal condition is count >= period-1, so a speed increase mid-count never overruns; on terminal, count returns to 0.
  - en=0: count holds.
- tick = (en & terminal) | (~en & step). step is ignored while en=1.
- Frame advance on tick:
  - forward: FRAMES-1 -> 0 (wrap=1), else +1.
  - reverse: 0 -> FRAMES-1 (wrap=1), else -1.
  - ping-pong: dir register; up at FRAMES-1 -> dir=down, frame FRAMES-2, wrap=1; down at 0 -> dir=up, frame 1, wrap=1.
  - hold: frame unchanged, wrap=0; tick still pulses.
- FRAMES=1: frame stays 0 in every mode. wrap pulses with every tick except in hold.
- dir is forced to up whenever mode != 10. Entering ping-pong therefore always starts upward.
- A frame index >= FRAMES is unreachable. If forced, the next tick returns it to 0 and the ROM shows blank (all 8'hFF).
- ROM frames: led3..led0 patterns.
  - Frame 0 = FF,CF,F9,FF.
  - Frame 1 = FF,F9,CF,FF.
  - Frame 2 = F9,FF,FF,CF.
  - Frames 3+ = blank.
- Reset values: count 0, frame 0, dir up, tick 0, wrap 0. led outputs show frame 0: led0=FF, led1=F9, led2=CF, led3=FF.

## Timing
- tick and wrap are combinational from the count and inputs. They are high in the cycle count reaches period-1.
- frame and dir update on the clock edge ending the tick cycle, giving 1-cycle latency.
- led0..led3 are combinational from the frame register, with no added latency.
- step: a pulse in cycle n gives a new frame in cycle n+1. A step held for k cycles advances k frames.
- Asserting reset mid-operation clears all state immediately, without waiting for clk. Release is synchronous to the next rising clk edge.
- Toggling en or changing mode/speed is glitch-free. The change takes effect on the next cycle's evaluation.

## Structure
- Package heartbeat_pkg holds:
  - mode encodings MODE_FWD/REV/PING/HOLD;
  - BLANK = 8'hFF;
  - the default divisor;
  - the default frame-pattern constants.
- Sub-module anim_rom holds the pure combinational frame -> {led3,led2,led1,led0} lookup, parametrised by FRAME_W.
- Top level holds the divider, the frame/dir registers and the strobe logic.

## Test plan
- Reset: CLK_DIV=4, hold reset low for 3 cycles, then release with en=1, mode=00. Required: frame 0,0,0,0,1,…, tick every 4th cycle, leds initially FF/F9/CF/FF.
- Forward wrap: en=1, mode=00, FRAMES=3. Required: frame sequence 0,1,2,0, wrap=1 only on the 2->0 tick. Reverse (mode=01) gives 0,2,1,0, with wrap on 0->2.
- Ping-pong: mode=10 for 8 ticks. Required: frame 0,1,2,1,0,1,2,1,0, wrap on the 2->1 and 0->1 ticks.
- Speed and saturation: CLK_DIV=8. Switch speed 0->2 while count=5. Required: tick next cycle, then a period of 2. speed=3 with CLK_DIV=4 gives period 1 and a tick every cycle.
- Pause and step: en=0 for 20 cycles. Required: frame constant, no tick. A 1-cycle step gives tick=1 and a frame increment next cycle. A step while en=1 gives no extra tick.
- Hold and edge cases:
  - mode=11: ticks continue, frame is frozen, wrap=0.
  - FRAMES=1: frame always 0, wrap on every tick.
  - reset asserted mid-count: frame returns to 0 before the next clk edge.

Source files
------------

// File: rtl/heartbeat_pkg.sv
// heartbeat_pkg: shared constants for the heartbeat frame animator.
//   - mode encodings for the frame sequencer
//   - ping-pong direction encodings
//   - blank segment pattern and default divisor
//   - default frame patterns, packed as {led3, led2, led1, led0}
package heartbeat_pkg;

  localparam logic [1:0] MODE_FWD  = 2'b00;
  localparam logic [1:0] MODE_REV  = 2'b01;
  localparam logic [1:0] MODE_PING = 2'b10;
  localparam logic [1:0] MODE_HOLD = 2'b11;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Active-low segments: all ones means every segment (and dp) off.
  localparam logic [7:0] BLANK = 8'hFF;

  // 72 Hz frame rate from a 100 MHz clock at speed 0.
  localparam int DEFAULT_CLK_DIV = 1388889;

  localparam logic [31:0] FRAME0_PAT = {8'hFF, 8'hCF, 8'hF9, 8'hFF};
  localparam logic [31:0] FRAME1_PAT = {8'hFF, 8'hF9, 8'hCF, 8'hFF};
  localparam logic [31:0] FRAME2_PAT = {8'hF9, 8'hFF, 8'hFF, 8'hCF};

endpackage

// File: rtl/anim_rom.sv
// anim_rom: combinational frame index -> segment pattern lookup.
// Ports:
//   frame   in  FRAME_W  frame index
//   pattern out 32       {led3, led2, led1, led0}, active-low segments
// Indices without a stored pattern return blank on all four digits.
module anim_rom
  import heartbeat_pkg::*;
#(
  parameter int FRAME_W = 3
) (
  input  logic [FRAME_W-1:0] frame,
  output logic [31:0]        pattern
);

  always_comb begin
    pattern = {4{BLANK}};
    case (32'(frame))
      0:       pattern = FRAME0_PAT;
      1:       pattern = FRAME1_PAT;
      2:       pattern = FRAME2_PAT;
      default: pattern = {4{BLANK}};
    endcase
  end

endmodule

// File: rtl/heartbeat_anim.sv
// heartbeat_anim: frame-animation generator for the 4-digit 7-segment display.
// A programmable divider paces a frame counter that walks the pattern ROM in
// forward, reverse, ping-pong or hold order, with run/pause and single-step.
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   asynchronous active-low reset
//   en           in   1 = run, 0 = pause
//   mode         in   00 fwd-wrap, 01 rev-wrap, 10 ping-pong, 11 hold
//   speed        in   frame period = max(1, CLK_DIV >> speed)
//   step         in   advances one frame per cycle held while en=0
//   tick         out  frame-advance strobe (combinational)
//   wrap         out  end-of-sequence strobe, coincident with tick
//   frame        out  current frame index
//   led0..led3   out  active-low segment patterns, dp in bit 7
module heartbeat_anim
  import heartbeat_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV,
  parameter int DIV_W   = 22,
  parameter int FRAMES  = 3,
  parameter int FRAME_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [1:0]         mode,
  input  logic [1:0]         speed,
  input  logic               step,
  output logic               tick,
  output logic               wrap,
  output logic [FRAME_W-1:0] frame,
  output logic [7:0]         led0,
  output logic [7:0]         led1,
  output logic [7:0]         led2,
  output logic [7:0]         led3
);

  localparam logic [DIV_W-1:0]   DIV_VAL = DIV_W'(CLK_DIV);
  localparam logic [FRAME_W-1:0] LAST    = FRAME_W'(FRAMES - 1);

  logic [DIV_W-1:0]   count_reg, count_next;
  logic [DIV_W-1:0]   period;
  logic               terminal;
  logic [FRAME_W-1:0] frame_reg, frame_next;
  logic               dir_reg, dir_next;
  logic               wrap_cond;
  logic [31:0]        pattern;

  // ---------------- divider ----------------
  always_comb begin
    period = DIV_VAL >> speed;
    if (period == '0) begin
      period = DIV_W'(1);
    end
  end

  // ">=" rather than "==" so a period shortened mid-count terminates at once
  // instead of running on to the counter's wrap.
  assign terminal = (count_reg >= (period - DIV_W'(1)));

  always_comb begin
    count_next = count_reg;
    if (en) begin
      count_next = terminal ? '0 : count_reg + DIV_W'(1);
    end
  end

  assign tick = en ? terminal : step;

  // ---------------- frame sequencer ----------------
  always_comb begin
    frame_next = frame_reg;
    dir_next   = dir_reg;
    wrap_cond  = 1'b0;
    if (frame_reg > LAST) begin
      // Out-of-range index (only reachable by forcing): recover to frame 0.
      frame_next = '0;
    end else if (FRAMES == 1) begin
      frame_next = '0;
      wrap_cond  = (mode != MODE_HOLD);
    end else begin
      case (mode)
        MODE_FWD: begin
          if (frame_reg == LAST) begin
            frame_next = '0;
            wrap_cond  = 1'b1;
          end else begin
            frame_next = frame_reg + FRAME_W'(1);
          end
        end
        MODE_REV: begin
          if (frame_reg == '0) begin
            frame_next = LAST;
            wrap_cond  = 1'b1;
          end else begin
            frame_next = frame_reg - FRAME_W'(1);
          end
        end
        MODE_PING: begin
          if (dir_reg == DIR_UP) begin
            if (frame_reg == LAST) begin
              frame_next = LAST - FRAME_W'(1);
              dir_next   = DIR_DOWN;
              wrap_cond  = 1'b1;
            end else begin
              frame_next = frame_reg + FRAME_W'(1);
            end
          end else begin
            if (frame_reg == '0) begin
              frame_next = FRAME_W'(1);
              dir_next   = DIR_UP;
              wrap_cond  = 1'b1;
            end else begin
              frame_next = frame_reg - FRAME_W'(1);
            end
          end
        end
        default: begin
          frame_next = frame_reg;
        end
      endcase
    end
    // Outside ping-pong the direction is pinned up, so re-entering ping-pong
    // always starts upward.
    if (mode != MODE_PING) begin
      dir_next = DIR_UP;
    end
  end

  assign wrap = tick & wrap_cond;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
      frame_reg <= '0;
      dir_reg   <= DIR_UP;
    end else begin
      count_reg <= count_next;
      if (tick) begin
        frame_reg <= frame_next;
        dir_reg   <= dir_next;
      end else if (mode != MODE_PING) begin
        dir_reg   <= DIR_UP;
      end
    end
  end

  // ---------------- pattern output ----------------
  anim_rom #(
    .FRAME_W(FRAME_W)
  ) u_rom (
    .frame  (frame_reg),
    .pattern(pattern)
  );

  assign frame = frame_reg;

  always_comb begin
    if (frame_reg > LAST) begin
      {led3, led2, led1, led0} = {4{BLANK}};
    end else begin
      {led3, led2, led1, led0} = pattern;
    end
  end

endmodule
